// File: rtl/mux_l2_serializer.sv
// mux_l2_serializer: four parallel byte lanes -> one byte stream at 4x rate.
// All lanes are captured together at phase 0 into a shadow frame. The shadow
// frame is then emitted one lane per cycle, lane 0 first, with selector and
// valid telling the downstream demux which lane each byte belongs to.
module mux_l2_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [WIDTH-1:0] Entrada0,
  input  logic [WIDTH-1:0] Entrada1,
  input  logic [WIDTH-1:0] Entrada2,
  input  logic [WIDTH-1:0] Entrada3,
  input  logic             validEntrada0,
  input  logic             validEntrada1,
  input  logic             validEntrada2,
  input  logic             validEntrada3,
  output logic [WIDTH-1:0] Salida,
  output logic             validSalida,
  output logic [1:0]       selector,
  output logic             frame_start,
  output logic             fsm_run
);

  // Stream handshake: no ready signal. validSalida qualifies Salida in the
  // same cycle and the receiver must take one slot every clk_4f cycle.

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [1:0]       ph_q;
  logic [WIDTH-1:0] shadow_d_q [4];
  logic             shadow_v_q [4];

  logic [WIDTH-1:0] in_d [4];
  logic             in_v [4];
  logic [1:0]       lane;
  logic [WIDTH-1:0] salida_d;
  logic             valid_d;

  // Gather the lane inputs into arrays and pick the lane emitted this phase.
  // Phase p emits lane p-1 (mod 4): lane 3 leaves on the same edge that
  // recaptures the frame, so it reads the shadow before it is overwritten.
  always_comb begin
    in_d[0]  = Entrada0;
    in_d[1]  = Entrada1;
    in_d[2]  = Entrada2;
    in_d[3]  = Entrada3;
    in_v[0]  = validEntrada0;
    in_v[1]  = validEntrada1;
    in_v[2]  = validEntrada2;
    in_v[3]  = validEntrada3;
    lane     = ph_q - 2'd1;
    valid_d  = shadow_v_q[lane];
    salida_d = shadow_v_q[lane] ? shadow_d_q[lane] : '0;
  end

  // Phase counter, frame capture, FSM and registered outputs.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q     <= IDLE;
      ph_q        <= 2'd0;
      Salida      <= '0;
      validSalida <= 1'b0;
      selector    <= 2'd0;
      frame_start <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        shadow_d_q[k] <= '0;
        shadow_v_q[k] <= 1'b0;
      end
    end else begin
      ph_q <= ph_q + 2'd1;
      if (ph_q == 2'd0) begin
        for (int k = 0; k < 4; k++) begin
          shadow_d_q[k] <= in_d[k];
          shadow_v_q[k] <= in_v[k];
        end
      end
      case (state_q)
        IDLE: begin
          // First edge out of reset only captures; nothing is emitted yet.
          state_q     <= RUN;
          Salida      <= '0;
          validSalida <= 1'b0;
          selector    <= 2'd0;
          frame_start <= 1'b0;
        end
        RUN: begin
          state_q     <= RUN;
          selector    <= lane;
          validSalida <= valid_d;
          Salida      <= salida_d;
          frame_start <= (lane == 2'd0);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fsm_run = (state_q == RUN);

endmodule

// File: tb/tb_mux_l2_serializer.sv
// Bench for mux_l2_serializer. The reference model counts edges since reset
// release: edge 1 captures frame 0, edge n>=2 emits lane (n-2)%4 of the most
// recently captured frame (captures happen on edges 1,5,9,...).
module tb_mux_l2_serializer;

  localparam int W = 8;

  logic         clk_4f = 1'b0;
  logic         reset;
  logic [W-1:0] ent [4];
  logic         vent [4];
  logic [W-1:0] Salida;
  logic         validSalida;
  logic [1:0]   selector;
  logic         frame_start;
  logic         fsm_run;

  int tests_run = 0;
  int tests_failed = 0;

  // model state
  int           n;
  logic [W-1:0] fr_d [4];
  logic         fr_v [4];
  logic [W-1:0] exp_s;
  logic         exp_v;
  logic [1:0]   exp_sel;
  logic         exp_fs;
  logic [4*(W+1)-1:0] exp_q[$];

  mux_l2_serializer #(.WIDTH(W)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .Entrada0(ent[0]), .Entrada1(ent[1]), .Entrada2(ent[2]), .Entrada3(ent[3]),
    .validEntrada0(vent[0]), .validEntrada1(vent[1]),
    .validEntrada2(vent[2]), .validEntrada3(vent[3]),
    .Salida(Salida), .validSalida(validSalida), .selector(selector),
    .frame_start(frame_start), .fsm_run(fsm_run)
  );

  // clock
  always #5 clk_4f = ~clk_4f;

  // Advance one edge, update the model, then settle 1ns past the edge.
  task automatic tick();
    int l;
    logic [4*(W+1)-1:0] rec;
    @(posedge clk_4f);
    if (reset) begin
      n = 0;
      exp_s = '0; exp_v = 1'b0; exp_sel = 2'd0; exp_fs = 1'b0;
    end else begin
      n++;
      if (n >= 2) begin
        l = (n - 2) % 4;
        exp_sel = 2'(l);
        exp_v   = fr_v[l];
        exp_s   = fr_v[l] ? fr_d[l] : '0;
        exp_fs  = (l == 0);
      end else begin
        exp_s = '0; exp_v = 1'b0; exp_sel = 2'd0; exp_fs = 1'b0;
      end
      if (n % 4 == 1) begin
        rec = '0;
        for (int k = 0; k < 4; k++) begin
          fr_d[k] = ent[k];
          fr_v[k] = vent[k];
          rec[k*(W+1) +: (W+1)] = {vent[k], vent[k] ? ent[k] : 8'h00};
        end
        exp_q.push_back(rec);
      end
    end
    #1;
  endtask

  task automatic set_lanes(input logic [W-1:0] d0, d1, d2, d3,
                           input logic v0, v1, v2, v3);
    ent[0] = d0; ent[1] = d1; ent[2] = d2; ent[3] = d3;
    vent[0] = v0; vent[1] = v1; vent[2] = v2; vent[3] = v3;
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < 4; k++) begin
      ent[k]  = W'($urandom_range(0, 255));
      vent[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      tick();
      tests_run++;
      if ({Salida, validSalida, selector, frame_start} !== {8'h00, 1'b0, 2'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset cyc%0d got s=%h v=%b sel=%0d fs=%b exp all zero",
                 i, Salida, validSalida, selector, frame_start);
      end
    end
  endtask

  task automatic test_all_valid();
    set_lanes(8'h01, 8'h02, 8'h03, 8'h04, 1, 1, 1, 1);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      tests_run++;
      if ({Salida, validSalida, selector, frame_start} !== {exp_s, exp_v, exp_sel, exp_fs}) begin
        tests_failed++;
        $display("FAIL all_valid n=%0d got s=%h v=%b sel=%0d fs=%b exp s=%h v=%b sel=%0d fs=%b",
                 n, Salida, validSalida, selector, frame_start, exp_s, exp_v, exp_sel, exp_fs);
      end
      if (n == 2) begin
        tests_run++;
        if (Salida !== 8'h01 || frame_start !== 1'b1 || validSalida !== 1'b1) begin
          tests_failed++;
          $display("FAIL first_byte got s=%h fs=%b v=%b exp s=01 fs=1 v=1",
                   Salida, frame_start, validSalida);
        end
      end
    end
  endtask

  task automatic test_invalid_lane();
    set_lanes(8'h01, 8'h02, 8'h03, 8'hAA, 1, 1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      tests_run++;
      if ({Salida, validSalida, selector, frame_start} !== {exp_s, exp_v, exp_sel, exp_fs}) begin
        tests_failed++;
        $display("FAIL invalid_lane n=%0d got s=%h v=%b sel=%0d fs=%b exp s=%h v=%b sel=%0d fs=%b",
                 n, Salida, validSalida, selector, frame_start, exp_s, exp_v, exp_sel, exp_fs);
      end
    end
  endtask

  task automatic test_midframe_change();
    logic [W-1:0] slot1 [$];
    set_lanes(8'h01, 8'h02, 8'h03, 8'h04, 1, 1, 1, 1);
    // let the new values settle into a full frame, then align to ph==2
    for (int i = 0; i < 12 && !(i >= 4 && n % 4 == 2); i++) tick();
    ent[1] = 8'h55;
    for (int i = 0; i < 9; i++) begin
      tick();
      tests_run++;
      if ({Salida, validSalida, selector, frame_start} !== {exp_s, exp_v, exp_sel, exp_fs}) begin
        tests_failed++;
        $display("FAIL midframe n=%0d got s=%h v=%b sel=%0d fs=%b exp s=%h v=%b sel=%0d fs=%b",
                 n, Salida, validSalida, selector, frame_start, exp_s, exp_v, exp_sel, exp_fs);
      end
      if (selector == 2'd1) slot1.push_back(Salida);
    end
    tests_run++;
    if (slot1.size() < 2 || slot1[0] !== 8'h02 || slot1[1] !== 8'h55) begin
      tests_failed++;
      $display("FAIL midframe_slot1 got n=%0d first=%h second=%h exp 02 then 55",
               slot1.size(), slot1.size() > 0 ? slot1[0] : 8'hxx,
               slot1.size() > 1 ? slot1[1] : 8'hxx);
    end
  endtask

  task automatic test_reset_midframe();
    int guard = 0;
    while (!(n >= 2 && exp_sel == 2'd2) && guard < 8) begin
      tick();
      guard++;
    end
    tests_run++;
    if (selector !== 2'd2) begin
      tests_failed++;
      $display("FAIL rst_mid_align got sel=%0d exp 2", selector);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if ({Salida, validSalida, selector, frame_start} !== {8'h00, 1'b0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_mid_zero got s=%h v=%b sel=%0d fs=%b exp all zero",
               Salida, validSalida, selector, frame_start);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if ({Salida, validSalida, selector, frame_start} !== {8'h00, 1'b0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_mid_stale got s=%h v=%b sel=%0d fs=%b exp all zero",
               Salida, validSalida, selector, frame_start);
    end
    tick();
    tests_run++;
    if ({Salida, validSalida, selector, frame_start} !== {8'h01, 1'b1, 2'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL rst_mid_first got s=%h v=%b sel=%0d fs=%b exp s=01 v=1 sel=0 fs=1",
               Salida, validSalida, selector, frame_start);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      tick();
      tests_run++;
      if ({Salida, validSalida, selector, frame_start} !== {exp_s, exp_v, exp_sel, exp_fs}) begin
        tests_failed++;
        $display("FAIL random n=%0d got s=%h v=%b sel=%0d fs=%b exp s=%h v=%b sel=%0d fs=%b",
                 n, Salida, validSalida, selector, frame_start, exp_s, exp_v, exp_sel, exp_fs);
      end
    end
  endtask

  // Behavioural demux on the output stream: rebuild each frame by selector
  // and compare it with what was on the inputs at that frame's capture edge.
  task automatic test_loopback();
    logic [W:0] got [4];
    logic [4*(W+1)-1:0] want;
    logic [W-1:0] base = 8'h10;
    int frames = 0;
    reset = 1'b1;
    tick();
    exp_q.delete();
    reset = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) base = base + 8'd4;
      for (int k = 0; k < 4; k++) begin
        ent[k]  = base + W'(k);
        vent[k] = ($urandom_range(0, 4) != 0);
      end
      tick();
      if (n >= 2) begin
        got[selector] = {validSalida, Salida};
        if (selector == 2'd3) begin
          frames++;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL loopback frame=%0d got frame with no capture pending", frames);
          end else begin
            want = exp_q.pop_front();
            if ({got[3], got[2], got[1], got[0]} !== want) begin
              tests_failed++;
              $display("FAIL loopback frame=%0d got %h %h %h %h exp %h",
                       frames, got[3], got[2], got[1], got[0], want);
            end
          end
        end
      end
    end
    tests_run++;
    if (frames < 25) begin
      tests_failed++;
      $display("FAIL loopback_count got %0d frames exp at least 25", frames);
    end
  endtask

  initial begin
    reset = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      ent[k] = '0; vent[k] = 1'b0; fr_d[k] = '0; fr_v[k] = 1'b0;
    end
    exp_s = '0; exp_v = 1'b0; exp_sel = 2'd0; exp_fs = 1'b0;
    test_reset();
    test_all_valid();
    test_invalid_lane();
    test_midframe_change();
    test_reset_midframe();
    test_random();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
